// File: rtl/bldc_pkg.sv
// Shared BLDC commutation types: sequencer states and the six-step phase pattern.
package bldc_pkg;

    typedef enum logic [2:0] {IDLE, ALIGN, RAMP, RUN, COAST} bldc_state_t;

    // {R,G,B} phase enables indexed by step; step 0 is all-off.
    localparam logic [6:0][2:0] COMM_PATTERN = {
        3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b000
    };

    function automatic logic [2:0] comm_pattern(input logic [2:0] step);
        logic [2:0] pat;
        pat = 3'b000;
        if (step <= 3'd6) pat = COMM_PATTERN[step];
        return pat;
    endfunction

endpackage

// File: rtl/bldc_pwm_cnt.sv
// Free-running PWM counter with registered on/off compare against duty.
module bldc_pwm_cnt
    import bldc_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                sysclk,
    input  logic                sysrst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on
);

    logic [PWM_BITS-1:0] cnt;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            cnt    <= '0;
            pwm_on <= 1'b0;
        end else begin
            cnt    <= cnt + PWM_BITS'(1);
            pwm_on <= (cnt < duty);
        end
    end

endmodule

// File: rtl/bldc_comm_seq.sv
// Six-step BLDC commutation sequencer: align, open-loop ramp to target period,
// run, and coast with all phases off on stop or direction reversal.
module bldc_comm_seq
    import bldc_pkg::*;
#(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PERIOD_W     = 16,
    parameter int unsigned START_PERIOD = 48000,
    parameter int unsigned MIN_PERIOD   = 1500,
    parameter int unsigned RAMP_STEP    = 500,
    parameter int unsigned ALIGN_CYCLES = 480000,
    parameter int unsigned DEAD_CYCLES  = 4800
) (
    input  logic                sysclk,
    input  logic                sysrst_n,
    input  logic                motor_on,
    input  logic                motor_dir,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PERIOD_W-1:0] target_period,
    output logic [2:0]          phase,
    output logic [2:0]          step_idx,
    output logic                running,
    output logic                at_speed
);

    localparam int unsigned TMR_W = 32;

    bldc_state_t         state;
    logic [2:0]          step;
    logic [TMR_W-1:0]    timer;
    logic [PERIOD_W-1:0] cur_period;
    logic                dir_lat;
    logic                pwm_on;

    logic [PERIOD_W-1:0] tgt;
    logic [PERIOD_W:0]   ramp_diff;
    logic [2:0]          step_nxt;
    logic                active;
    logic                abort;
    logic                step_wrap;

    bldc_pwm_cnt #(.PWM_BITS(PWM_BITS)) u_pwm (
        .sysclk   (sysclk),
        .sysrst_n (sysrst_n),
        .duty     (duty),
        .pwm_on   (pwm_on)
    );

    assign tgt = (target_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD)
                                                         : target_period;
    // Top bit is the borrow of the ramp decrement.
    assign ramp_diff = {1'b0, cur_period} - (PERIOD_W + 1)'(RAMP_STEP);
    assign step_nxt  = dir_lat ? ((step >= 3'd6) ? 3'd1 : step + 3'd1)
                               : ((step <= 3'd1) ? 3'd6 : step - 3'd1);
    assign active    = (state == ALIGN) || (state == RAMP) || (state == RUN);
    assign abort     = active && (!motor_on || (motor_dir != dir_lat));
    assign step_wrap = (timer == TMR_W'(cur_period) - TMR_W'(1));

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            state      <= IDLE;
            step       <= 3'd0;
            timer      <= '0;
            cur_period <= '0;
            dir_lat    <= 1'b0;
            phase      <= 3'b000;
            step_idx   <= 3'd0;
            running    <= 1'b0;
            at_speed   <= 1'b0;
        end else begin
            step_idx <= step;
            running  <= active;
            at_speed <= (state == RUN);
            phase    <= (pwm_on && active) ? comm_pattern(step) : 3'b000;
            timer    <= timer + TMR_W'(1);

            if (abort) begin
                state <= COAST;
                step  <= 3'd0;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        timer <= '0;
                        if (motor_on) begin
                            state   <= ALIGN;
                            step    <= 3'd1;
                            dir_lat <= motor_dir;
                        end
                    end
                    ALIGN: begin
                        if (timer == TMR_W'(ALIGN_CYCLES - 1)) begin
                            state      <= RAMP;
                            step       <= step_nxt;
                            timer      <= '0;
                            cur_period <= PERIOD_W'(START_PERIOD);
                        end
                    end
                    RAMP: begin
                        if (step_wrap) begin
                            step  <= step_nxt;
                            timer <= '0;
                            if (ramp_diff[PERIOD_W] || (ramp_diff[PERIOD_W-1:0] <= tgt)) begin
                                cur_period <= tgt;
                                state      <= RUN;
                            end else begin
                                cur_period <= ramp_diff[PERIOD_W-1:0];
                            end
                        end
                    end
                    RUN: begin
                        // Slower targets apply at once; faster ones go back through the ramp.
                        if (step_wrap) begin
                            step  <= step_nxt;
                            timer <= '0;
                            if (tgt >= cur_period) cur_period <= tgt;
                            else                   state      <= RAMP;
                        end
                    end
                    COAST: begin
                        if (timer == TMR_W'(DEAD_CYCLES - 1)) begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/bldc_comm_seq.md
# bldc_comm_seq

Six-step commutation sequencer for the three-phase BLDC output stage driven through the RGB LED driver pins. It takes run/direction/duty/speed settings from the I2C command decoder and drives the three phase-enable bits with PWM gating. It aligns the rotor, ramps the step period down to the target speed and coasts safely on stop or direction reversal.

## Interface
- PWM_BITS, 8: duty and PWM counter width
- PERIOD_W, 16: step-period counter width
- START_PERIOD, 48000: first open-loop step period in sysclk cycles (1 ms at 48 MHz)
- MIN_PERIOD, 1500: floor for any step period
- RAMP_STEP, 500: period decrement applied per commutation step while ramping
- ALIGN_CYCLES, 480000: rotor-alignment hold time
- DEAD_CYCLES, 4800: all-off coast time before returning to IDLE
- sysclk  in  1  system clock (48 MHz HFOSC)
- sysrst_n  in  1  asynchronous active-low reset
- motor_on  in  1  level; 1 = run request
- motor_dir  in  1  0 = clockwise (step index decrements), 1 = counter-clockwise (increments)
- duty  in  PWM_BITS  PWM duty; on-time is duty/2^PWM_BITS
- target_period  in  PERIOD_W  requested step period; values < MIN_PERIOD are treated as MIN_PERIOD
- phase  out  3  {R,G,B} phase enables to the RGB driver PWM inputs
- step_idx  out  3  current commutation step, 1..6; 0 when not driving
- running  out  1  high in ALIGN, RAMP and RUN
- at_speed  out  1  high only in RUN

## Operation
- Pattern table: step 1..6 = 100, 110, 010, 011, 001, 101. Step 0 = 000 (off).
- Direction handling:
  - dir_lat captures motor_dir on the IDLE->ALIGN transition.
  - dir_lat=0: next step = step-1, and 1 wraps to 6.
  - dir_lat=1: next step = step+1, and 6 wraps to 1.
- PWM: free-running PWM_BITS counter, wraps 2^PWM_BITS-1 -> 0. pwm_on = (cnt < duty).
  - duty=0 means never on.
  - duty=255 means on 255 of every 256 cycles.
- phase = pattern[step_idx] when pwm_on and running; otherwise 000.
- States:
  - IDLE: outputs off.
    - motor_on=1 -> ALIGN, with step_idx=1 and timer cleared.
  - ALIGN: holds step 1 for ALIGN_CYCLES.
    - On timeout: cur_period <= START_PERIOD, step timer cleared -> RAMP.
  - RAMP: step timer counts 0..cur_period-1. On wrap, advance the step and set cur_period <= cur_period-RAMP_STEP.
    - If that result is <= tgt, or would underflow, load cur_period <= tgt and go to RUN.
    - tgt is the clamped target_period.
    - If START_PERIOD <= tgt, the first wrap goes straight to RUN.
  - RUN: the step advances on each timer wrap.
    - At the wrap, if tgt >= cur_period, load cur_period <= tgt (immediate deceleration).
    - If tgt < cur_period -> RAMP, and at_speed drops.
  - COAST: step_idx=0, phase=000; after DEAD_CYCLES -> IDLE.
- Exits to COAST:
  - motor_on=0 in ALIGN, RAMP or RUN -> COAST.
  - motor_dir != dir_lat in ALIGN, RAMP or RUN -> COAST. If motor_on is still 1, the sequence restarts from IDLE with the new direction.
- motor_on and motor_dir changes during COAST are ignored until IDLE. IDLE re-samples both.
- duty and target_period may change at any time:
  - duty takes effect on the next PWM compare.
  - target_period is sampled only at step boundaries.

## Timing
- All outputs are registered.
- Reset values: phase=000, step_idx=0, running=0, at_speed=0. Internal: state=IDLE, all counters 0, dir_lat=0.
- Reset mid-operation forces all-off immediately (asynchronous). There is no coast on reset.
- Latencies:
  - motor_on rising edge in IDLE to running=1 and step_idx=1: 2 cycles (1 to register state, 1 to output).
  - ALIGN lasts exactly ALIGN_CYCLES cycles of step_idx=1.
  - Each step lasts exactly cur_period cycles.
  - motor_on falling edge to phase=000: 2 cycles.
  - COAST lasts exactly DEAD_CYCLES cycles.
- Step period arithmetic is unsigned PERIOD_W. The subtraction is checked for borrow before it is applied.
- Simultaneous motor_on=0 and a direction change: treated as stop, so the block goes to IDLE and stays there.

## Structure
- Shared package bldc_pkg holds the state enum (IDLE, ALIGN, RAMP, RUN, COAST) and the 6-entry commutation pattern constant. The I2C command decoder reuses the pattern constant.
- One sub-module, bldc_pwm_cnt: the PWM counter plus comparator, outputting pwm_on. Everything else stays in bldc_comm_seq.

## Test plan
Bench parameters: START_PERIOD=40, MIN_PERIOD=8, RAMP_STEP=8, ALIGN_CYCLES=16, DEAD_CYCLES=10, PWM_BITS=8.
- Reset release, motor_on=0, duty=128 -> phase=000, step_idx=0, running=0 for 1000 cycles.
- motor_on=1, dir=0, target=16, duty=255:
  - ALIGN of 16 cycles on step 1.
  - Step periods 40, 32, 24, then 16 with at_speed=1.
  - Step order 1,6,5,4,3,2,1.
- In RUN with dir=1, target 16 -> 8: RAMP re-entered, at_speed=0; periods 16, 8; at_speed=1 again; order 1,2,3,...
- duty=0 -> phase=000 throughout while step_idx still advances. duty=64 -> phase nonzero exactly 64 of every 256 cycles.
- In RUN, toggle motor_dir:
  - phase=000 within 2 cycles, COAST of 10 cycles, IDLE.
  - Then ALIGN restarts with the new direction's step order.
- Assert sysrst_n mid-RAMP -> outputs 0 in the same cycle. Release with motor_on=1 -> full ALIGN sequence restarts.
